fir_out_axis: RTL and testbench
===============================

FIR_OUT_AXIS -- requirements
Module: fir_out_axis

Interface
REQ-001 Parameter IN_W, 32, width of signed FIR output sample consumed.
REQ-002 Parameter OUT_W, 16, width of signed requantized output sample.
REQ-003 Parameter FIFO_DEPTH, 16, output buffer entries; power of two, at least 4.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  IN_W  signed sample, connected to FIR filtered_signal.
REQ-007 in_valid  input  1  in_data qualifier; tied high for a free-running FIR.
REQ-008 en  input  1  block enable; low holds the decimator idle, and no FIFO pushes occur.
REQ-009 shift  input  5  arithmetic right-shift amount, 0..31.
REQ-010 decim  input  8  decimation ratio D; value 0 is treated as 1.
REQ-011 clr_flags  input  1  single-cycle pulse clearing sticky flags.
REQ-012 m_axis_tdata  output  OUT_W  AXI4-Stream data, head of FIFO.
REQ-013 m_axis_tvalid  output  1  FIFO not empty.
REQ-014 m_axis_tready  input  1  downstream accept.
REQ-015 sat_flag  output  1  sticky; set when any kept sample saturated.
REQ-016 ovf_flag  output  1  sticky; set when any kept sample was dropped on a full FIFO.

Function
REQ-017 shift and decim SHALL be captured into internal registers in the cycle en is low; they SHALL be ignored while en is high.
REQ-018 Decimation counter SHALL be 0 while en is low, advance on each in_valid with en high, and wrap at D-1; the sample SHALL be kept when the count is 0, so the first valid sample after en rises is kept.
REQ-019 Stage 1 SHALL register the kept sample and a keep bit; stage 2 SHALL register the requantized value; stage 3 SHALL push it into the FIFO.
REQ-020 Requantization SHALL compute in IN_W+1 bits: y = (x + (shift>0 ? 2^(shift-1) : 0)) >>> shift, i.e. round half toward +inf.
REQ-021 Saturation SHALL clamp y to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and SHALL set sat_flag on clamping.
REQ-022 A sample presented in cycle k SHALL appear on m_axis_tdata with tvalid high in cycle k+3 when the FIFO is empty.
REQ-023 A pop SHALL occur when m_axis_tvalid and m_axis_tready are both high; tdata and tvalid SHALL NOT change while tvalid is high and tready is low.
REQ-024 A push SHALL be accepted if the FIFO is not full or a pop occurs in the same cycle; otherwise the sample SHALL be dropped and ovf_flag SHALL be set.
REQ-025 Simultaneous push and pop on an empty FIFO: the pop is not possible, so the push SHALL be stored.
REQ-026 Output order SHALL equal the order of kept input samples.
REQ-027 clr_flags SHALL clear both flags; a set event in the same cycle SHALL take priority.
REQ-028 en falling SHALL NOT flush the FIFO or pipeline; in-flight samples SHALL drain normally.

Reset
REQ-029 While resetn is low: m_axis_tvalid=0, m_axis_tdata=0, sat_flag=0, ovf_flag=0, FIFO pointers=0, pipeline valid bits=0, decimation counter=0, shift register=0, decim register=1.
REQ-030 Reset mid-operation SHALL discard all buffered and in-flight samples; no stale data SHALL appear after release.

Structure
REQ-031 Package fir_out_pkg SHALL hold IN_W/OUT_W defaults, FIFO_DEPTH default, and the OUT_W saturation limit constants.
REQ-032 Buffer SHALL be a sub-module fir_out_fifo: synchronous, first-word-fall-through, with count-based full/empty; the pipeline and decimator SHALL be in the top module.

Verification
REQ-033 Rounding: shift=15, D=1, in_data 0x00004000 then 0x00003FFF -> tdata 0x0001 at k+3, then 0x0000.
REQ-034 Negative rounding and saturation: shift=1, in -3 -> 0xFFFF; shift=0, in 0x00010000 -> 0x7FFF with sat_flag=1; shift=0, in 0xFFFF0000 -> 0x8000.
REQ-035 Decimation: decim=4, shift=0, ramp 0..15 -> outputs 0,4,8,12 only.
REQ-036 Backpressure: tready=0, D=1, ramp 0..19 -> 16 entries held, ovf_flag=1; then tready=1 -> 0..15 in order, tvalid low after.
REQ-037 Reset mid-stream: resetn low with 5 entries buffered -> tvalid=0 and flags=0 immediately; after release and en high, the first output is the first new sample.
REQ-038 Flag race: clr_flags asserted in the same cycle as a saturation event -> sat_flag remains 1.

Source files
------------

// File: rtl/fir_out_pkg.sv
// fir_out_pkg: default widths, buffer depth and output saturation limits for fir_out_axis.
package fir_out_pkg;
  localparam int IN_W_DEF = 32;
  localparam int OUT_W_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 16;
  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction
  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction
  localparam longint OUT_MAX = sat_max(OUT_W_DEF);
  localparam longint OUT_MIN = sat_min(OUT_W_DEF);
endpackage

// File: rtl/fir_out_fifo.sv
// fir_out_fifo: synchronous first-word-fall-through buffer with count-based full/empty.
module fir_out_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] cnt_q;
  logic push, pop;
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign pop = rd_en_i && !empty_o;
  // a pop frees the slot this same cycle, so a full buffer still accepts
  assign push = wr_en_i && (!full_o || pop);
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/fir_out_axis.sv
// fir_out_axis: decimates, requantizes and saturates FIR output samples, then
// buffers them onto an AXI4-Stream master with sticky saturation/overflow flags.
module fir_out_axis
  import fir_out_pkg::*;
#(
  parameter int IN_W = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic             en,
  input  logic [4:0]       shift,
  input  logic [7:0]       decim,
  input  logic             clr_flags,
  output logic [OUT_W-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             sat_flag,
  output logic             ovf_flag
);
  localparam logic signed [IN_W:0] Y_MAX = (IN_W+1)'(sat_max(OUT_W));
  localparam logic signed [IN_W:0] Y_MIN = (IN_W+1)'(sat_min(OUT_W));
  logic [4:0] shift_q, s1_shift_q;
  logic [7:0] decim_q, cnt_q, cnt_d, d_eff;
  logic keep, s1_vld_q, s2_vld_q;
  logic signed [IN_W-1:0] s1_data_q;
  logic [OUT_W-1:0] s2_data_q, q;
  logic signed [IN_W:0] rnd, y;
  logic clamp_hi, clamp_lo, sat_q, sat_d, ovf_q, ovf_d;
  logic full, empty, pop, sat_set, ovf_set;
  assign d_eff = decim_q == 8'd0 ? 8'd1 : decim_q;
  assign keep = en && in_valid && cnt_q == 8'd0;
  assign cnt_d = !en ? '0 : !in_valid ? cnt_q : (cnt_q == d_eff - 8'd1) ? '0 : cnt_q + 8'd1;
  // round half toward +inf, computed one bit wider so the rounding add cannot wrap
  always_comb begin
    rnd = s1_shift_q == 5'd0 ? '0 : (IN_W+1)'(1) << (s1_shift_q - 5'd1);
    y = ($signed({s1_data_q[IN_W-1], s1_data_q}) + rnd) >>> s1_shift_q;
    clamp_hi = y > Y_MAX;
    clamp_lo = y < Y_MIN;
    q = clamp_hi ? Y_MAX[OUT_W-1:0] : clamp_lo ? Y_MIN[OUT_W-1:0] : y[OUT_W-1:0];
  end
  assign m_axis_tvalid = !empty;
  assign pop = m_axis_tvalid && m_axis_tready;
  assign sat_set = s1_vld_q && (clamp_hi || clamp_lo);
  assign ovf_set = s2_vld_q && full && !pop;
  assign sat_d = sat_set || (sat_q && !clr_flags);
  assign ovf_d = ovf_set || (ovf_q && !clr_flags);
  assign sat_flag = sat_q;
  assign ovf_flag = ovf_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      shift_q <= '0;
      decim_q <= 8'd1;
      cnt_q <= '0;
      s1_vld_q <= 1'b0;
      s1_data_q <= '0;
      s1_shift_q <= '0;
      s2_vld_q <= 1'b0;
      s2_data_q <= '0;
      sat_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (!en) begin
        shift_q <= shift;
        decim_q <= decim;
      end
      cnt_q <= cnt_d;
      s1_vld_q <= keep;
      // the shift travels with the sample so in-flight data drains unaffected by reconfiguration
      if (keep) begin
        s1_data_q <= in_data;
        s1_shift_q <= shift_q;
      end
      s2_vld_q <= s1_vld_q;
      s2_data_q <= q;
      sat_q <= sat_d;
      ovf_q <= ovf_d;
    end
  fir_out_fifo #(.W(OUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .resetn(resetn),
    .wr_en_i(s2_vld_q),
    .wr_data_i(s2_data_q),
    .rd_en_i(m_axis_tready),
    .rd_data_o(m_axis_tdata),
    .full_o(full),
    .empty_o(empty)
  );
endmodule

// File: tb/tb_fir_out_axis.sv
// tb_fir_out_axis: directed and randomized checks of fir_out_axis against a queue-based reference model.
module tb_fir_out_axis;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic in_valid = 1'b0, en = 1'b0, clr_flags = 1'b0, m_axis_tready = 1'b0;
  logic [31:0] in_data = '0;
  logic [4:0] shift = '0;
  logic [7:0] decim = '0;
  logic [15:0] m_axis_tdata;
  logic m_axis_tvalid, sat_flag, ovf_flag;
  int n_chk = 0, n_fail = 0;
  int mq[$], pdue[$], pval[$], sdue[$], obs[$];
  bit m_sat, m_ovf;
  int m_shift, m_d, m_idx, edge_n;

  fir_out_axis dut (
    .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid), .en(en),
    .shift(shift), .decim(decim), .clr_flags(clr_flags), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .sat_flag(sat_flag), .ovf_flag(ovf_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint scaled(input logic [31:0] x, input int s);
    longint y;
    y = longint'($signed(x)) + (s > 0 ? (longint'(1) << (s - 1)) : 0);
    return y >>> s;
  endfunction

  task automatic model_reset();
    mq.delete(); pdue.delete(); pval.delete(); sdue.delete();
    m_sat = 0; m_ovf = 0; m_shift = 0; m_d = 1; m_idx = 0;
  endtask

  task automatic model_update();
    bit set_sat, set_ovf;
    longint y, c;
    int v;
    edge_n++;
    set_sat = 0;
    set_ovf = 0;
    if (!resetn) model_reset();
    else begin
      if (mq.size() > 0 && m_axis_tready) void'(mq.pop_front());
      while (pdue.size() > 0 && pdue[0] == edge_n) begin
        void'(pdue.pop_front());
        v = pval.pop_front();
        if (mq.size() < 16) mq.push_back(v); else set_ovf = 1;
      end
      while (sdue.size() > 0 && sdue[0] == edge_n) begin
        void'(sdue.pop_front());
        set_sat = 1;
      end
      m_sat = set_sat || (m_sat && !clr_flags);
      m_ovf = set_ovf || (m_ovf && !clr_flags);
      if (!en) begin
        m_idx = 0;
        m_shift = shift;
        m_d = decim == 0 ? 1 : int'(decim);
      end else if (in_valid) begin
        if (m_idx % m_d == 0) begin
          y = scaled(in_data, m_shift);
          c = y > 32767 ? 32767 : y < -32768 ? -32768 : y;
          pdue.push_back(edge_n + 2);
          pval.push_back(int'(c));
          if (c != y) sdue.push_back(edge_n + 1);
        end
        m_idx++;
      end
    end
  endtask

  task automatic tick();
    if (m_axis_tvalid && m_axis_tready) obs.push_back(int'($signed(m_axis_tdata)));
    @(posedge clk);
    model_update();
    @(negedge clk);
    check("tvalid", m_axis_tvalid, mq.size() > 0);
    check("tdata", m_axis_tdata, mq.size() > 0 ? (mq[0] & 32'hFFFF) : 0);
    check("sat_flag", sat_flag, m_sat);
    check("ovf_flag", ovf_flag, m_ovf);
  endtask

  task automatic cyc(input bit e, input bit v, input logic [31:0] d);
    en = e;
    in_valid = v;
    in_data = d;
    tick();
  endtask

  initial begin
    logic signed [31:0] r;
    model_reset();
    edge_n = 0;
    repeat (3) cyc(0, 0, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_flags", {sat_flag, ovf_flag}, 0);
    resetn = 1'b1;
    m_axis_tready = 1'b1;
    shift = 5'd15; decim = 8'd1;
    cyc(0, 0, 0);
    cyc(1, 1, 32'h0000_4000);
    cyc(1, 1, 32'h0000_3FFF);
    cyc(0, 0, 0);
    check("round_up", m_axis_tdata, 16'h0001);
    cyc(0, 0, 0);
    check("round_down", m_axis_tdata, 16'h0000);
    check("round_down_vld", m_axis_tvalid, 1);
    shift = 5'd1;
    cyc(0, 0, 0);
    cyc(1, 1, 32'hFFFF_FFFD);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("neg_round", m_axis_tdata, 16'hFFFF);
    shift = 5'd0;
    cyc(0, 0, 0);
    cyc(1, 1, 32'h0001_0000);
    cyc(0, 0, 0);
    check("sat_set", sat_flag, 1);
    cyc(0, 0, 0);
    check("sat_pos", m_axis_tdata, 16'h7FFF);
    cyc(1, 1, 32'hFFFF_0000);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("sat_neg", m_axis_tdata, 16'h8000);
    clr_flags = 1'b1;
    cyc(0, 0, 0);
    clr_flags = 1'b0;
    check("clr", sat_flag, 0);
    cyc(1, 1, 32'h0001_0000);
    clr_flags = 1'b1;
    cyc(0, 0, 0);
    clr_flags = 1'b0;
    check("flag_race", sat_flag, 1);
    clr_flags = 1'b1;
    cyc(0, 0, 0);
    clr_flags = 1'b0;
    check("clr_after_race", sat_flag, 0);
    repeat (4) cyc(0, 0, 0);
    obs.delete();
    decim = 8'd4;
    cyc(0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(1, 1, i);
    repeat (6) cyc(0, 0, 0);
    check("decim_cnt", obs.size(), 4);
    for (int i = 0; i < 4; i++) check("decim_val", obs.size() > i ? obs[i] : -1, 4 * i);
    m_axis_tready = 1'b0;
    decim = 8'd1;
    cyc(0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 1, i);
    repeat (4) cyc(0, 0, 0);
    check("bp_ovf", ovf_flag, 1);
    check("bp_head", m_axis_tdata, 0);
    obs.delete();
    m_axis_tready = 1'b1;
    repeat (20) cyc(0, 0, 0);
    check("bp_cnt", obs.size(), 16);
    for (int i = 0; i < 16; i++) check("bp_order", obs.size() > i ? obs[i] : -1, i);
    check("bp_empty", m_axis_tvalid, 0);
    m_axis_tready = 1'b0;
    clr_flags = 1'b1;
    cyc(0, 0, 0);
    clr_flags = 1'b0;
    cyc(1, 1, 32'h0001_0000);
    for (int i = 1; i < 5; i++) cyc(1, 1, i);
    repeat (3) cyc(0, 0, 0);
    check("pre_rst_sat", sat_flag, 1);
    resetn = 1'b0;
    #1;
    model_reset();
    check("mid_rst_tvalid", m_axis_tvalid, 0);
    check("mid_rst_tdata", m_axis_tdata, 0);
    check("mid_rst_flags", {sat_flag, ovf_flag}, 0);
    repeat (2) cyc(0, 0, 0);
    resetn = 1'b1;
    obs.delete();
    m_axis_tready = 1'b1;
    cyc(0, 0, 0);
    cyc(1, 1, 77);
    repeat (4) cyc(0, 0, 0);
    check("post_rst_first", obs.size() > 0 ? obs[0] : -1, 77);
    check("post_rst_cnt", obs.size(), 1);
    for (int n = 0; n < 600; n++) begin
      r = $urandom;
      shift = 5'($urandom_range(0, 31));
      decim = 8'($urandom_range(0, 5));
      m_axis_tready = $urandom_range(0, 2) != 0;
      clr_flags = $urandom_range(0, 15) == 0;
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, r >>> $urandom_range(0, 24));
    end
    clr_flags = 1'b0;
    m_axis_tready = 1'b1;
    repeat (25) cyc(0, 0, 0);
    check("final_empty", m_axis_tvalid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
